// File: rtl/led_tick_ctrl.sv
// rtl/led_tick_ctrl.sv - key debounce, speed/direction control and step tick for the water-LED shifter (optional pause key: LED_TICK_PAUSE_EN)

module key_debounce #(
    parameter logic [19:0] CNT_20MS = 20'd999_999
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key,
    output logic press
);

    logic        key_s1;
    logic        key_s2;
    logic [19:0] cnt;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            key_s1 <= 1'b1;
            key_s2 <= 1'b1;
            cnt    <= '0;
        end else begin
            key_s1 <= key;
            key_s2 <= key_s1;
            if (key_s2)
                cnt <= '0;
            else if (cnt != CNT_20MS)
                cnt <= cnt + 20'd1;
        end
    end

    // Saturation at CNT_20MS means the count passes CNT_20MS-1 only once per hold.
    assign press = !key_s2 && (cnt == CNT_20MS - 20'd1);

endmodule

module led_tick_ctrl #(
    parameter logic [19:0] CNT_20MS = 20'd999_999,
    parameter logic [24:0] TICK_MAX = 25'd24_999_999
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       key_speed,
    input  logic       key_dir,
`ifdef LED_TICK_PAUSE_EN
    input  logic       key_pause,
`endif
    output logic       tick_out,
    output logic [1:0] speed_lvl,
    output logic       dir_out,
    output logic       key_flag
);

    logic        press_speed;
    logic        press_dir;
    logic        press_pause;
    logic        run;
    logic [24:0] tick_cnt;
    logic [24:0] period;

    key_debounce #(.CNT_20MS(CNT_20MS)) u_db_speed (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key       (key_speed),
        .press     (press_speed)
    );

    key_debounce #(.CNT_20MS(CNT_20MS)) u_db_dir (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key       (key_dir),
        .press     (press_dir)
    );

`ifdef LED_TICK_PAUSE_EN
    key_debounce #(.CNT_20MS(CNT_20MS)) u_db_pause (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key       (key_pause),
        .press     (press_pause)
    );

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n)
            run <= 1'b1;
        else if (press_pause)
            run <= ~run;
    end
`else
    assign press_pause = 1'b0;
    assign run         = 1'b1;
`endif

    assign period = TICK_MAX >> speed_lvl;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            tick_out  <= 1'b0;
            speed_lvl <= 2'd0;
            dir_out   <= 1'b0;
            key_flag  <= 1'b0;
            tick_cnt  <= '0;
        end else begin
            key_flag <= press_speed | press_dir | press_pause;
            if (press_speed)
                speed_lvl <= speed_lvl + 2'd1;
            if (press_dir)
                dir_out <= ~dir_out;

            // A speed change restarts the period so the first new-speed tick is a full period away.
            if (press_speed) begin
                tick_cnt <= '0;
                tick_out <= 1'b0;
            end else if (!run) begin
                tick_out <= 1'b0;
            end else if (tick_cnt == period) begin
                tick_cnt <= '0;
                tick_out <= 1'b1;
            end else begin
                tick_cnt <= tick_cnt + 25'd1;
                tick_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_led_tick_ctrl.sv
// tb/tb_led_tick_ctrl.sv - directed table-driven bench for led_tick_ctrl (CNT_20MS=4, TICK_MAX=15)

module tb_led_tick_ctrl;

    localparam logic [19:0] CNT  = 20'd4;
    localparam logic [24:0] TMAX = 25'd15;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       key_speed = 1'b1;
    logic       key_dir   = 1'b1;
`ifdef LED_TICK_PAUSE_EN
    logic       key_pause = 1'b1;
`endif
    logic       tick_out;
    logic [1:0] speed_lvl;
    logic       dir_out;
    logic       key_flag;

    int tests    = 0;
    int fails    = 0;
    int flag_cnt = 0;
    int cycle    = 0;

    typedef struct {
        int hs;
        int hd;
        int flags;
        int speed;
        int dir;
        int period;
    } vec_t;

    vec_t vecs[8];

    led_tick_ctrl #(.CNT_20MS(CNT), .TICK_MAX(TMAX)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_speed (key_speed),
        .key_dir   (key_dir),
`ifdef LED_TICK_PAUSE_EN
        .key_pause (key_pause),
`endif
        .tick_out  (tick_out),
        .speed_lvl (speed_lvl),
        .dir_out   (dir_out),
        .key_flag  (key_flag)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic cyc();
        @(posedge sys_clk);
        @(negedge sys_clk);
        cycle++;
        if (key_flag === 1'b1)
            flag_cnt++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_tick(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            cyc();
            if (tick_out === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic measure_period(input string name, input int exp);
        int n;
        wait_tick(40, n);
        check({name, "_sync"}, (n > 0) ? 32'd1 : 32'd0, 32'd1);
        cyc();
        check({name, "_width"}, {31'd0, tick_out}, 32'd0);
        wait_tick(40, n);
        check(name, n + 1, exp);
    endtask

    task automatic press(input int hs, input int hd);
        int m;
        m = (hs > hd) ? hs : hd;
        for (int i = 0; i < m; i++) begin
            key_speed = !(i < hs);
            key_dir   = !(i < hd);
            cyc();
        end
        key_speed = 1'b1;
        key_dir   = 1'b1;
        repeat (8) cyc();
    endtask

    initial begin
        int n;
        int f0;
        int first;
        int ticks;

        vecs[0] = '{20, 0, 1, 2, 0, 4};
        vecs[1] = '{6,  0, 1, 3, 0, 2};
        vecs[2] = '{4,  0, 1, 0, 0, 16};
        vecs[3] = '{3,  0, 0, 0, 0, 16};
        vecs[4] = '{10, 10, 1, 1, 1, 8};
        vecs[5] = '{0,  6, 1, 1, 0, 8};
        vecs[6] = '{12, 0, 1, 2, 0, 4};
        vecs[7] = '{0,  5, 1, 2, 1, 4};

        sys_rst_n = 1'b0;
        repeat (3) cyc();
        check("rst_tick", {31'd0, tick_out}, 32'd0);
        check("rst_speed", {30'd0, speed_lvl}, 32'd0);
        check("rst_dir", {31'd0, dir_out}, 32'd0);
        check("rst_flag", {31'd0, key_flag}, 32'd0);

        sys_rst_n = 1'b1;
        wait_tick(40, n);
        check("first_tick", n, 16);
        measure_period("idle_period", 16);

        // Bounce: two 3-cycle lows are each one short of acceptance.
        f0 = flag_cnt;
        key_speed = 1'b0; repeat (3) cyc();
        key_speed = 1'b1; cyc();
        key_speed = 1'b0; repeat (3) cyc();
        key_speed = 1'b1; repeat (8) cyc();
        check("bounce_flags", flag_cnt - f0, 0);
        check("bounce_speed", {30'd0, speed_lvl}, 32'd0);

        // Speed change right after a tick: counter clears, first new tick 8 cycles after update.
        wait_tick(40, n);
        f0 = flag_cnt;
        first = -1;
        key_speed = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            cyc();
            if (i == 5) check("clr_speed_before", {30'd0, speed_lvl}, 32'd0);
            if (i == 6) begin
                check("clr_speed_after", {30'd0, speed_lvl}, 32'd1);
                key_speed = 1'b1;
            end
            if (tick_out === 1'b1 && first < 0) first = i;
        end
        check("clr_first_tick", first, 14);
        check("clr_flags", flag_cnt - f0, 1);

        for (int i = 0; i < 8; i++) begin
            f0 = flag_cnt;
            press(vecs[i].hs, vecs[i].hd);
            check($sformatf("row%0d_flags", i), flag_cnt - f0, vecs[i].flags);
            check($sformatf("row%0d_speed", i), {30'd0, speed_lvl}, vecs[i].speed);
            check($sformatf("row%0d_dir", i), {31'd0, dir_out}, vecs[i].dir);
            measure_period($sformatf("row%0d_period", i), vecs[i].period);
        end

        // Reset mid-count with a partially debounced press in flight.
        key_speed = 1'b0;
        repeat (2) cyc();
        sys_rst_n = 1'b0;
        key_speed = 1'b1;
        cyc();
        check("mid_rst_tick", {31'd0, tick_out}, 32'd0);
        check("mid_rst_speed", {30'd0, speed_lvl}, 32'd0);
        check("mid_rst_dir", {31'd0, dir_out}, 32'd0);
        check("mid_rst_flag", {31'd0, key_flag}, 32'd0);
        f0 = flag_cnt;
        sys_rst_n = 1'b1;
        wait_tick(40, n);
        check("mid_rst_first_tick", n, 16);
        check("mid_rst_no_flag", flag_cnt - f0, 0);
        check("mid_rst_speed_after", {30'd0, speed_lvl}, 32'd0);

`ifdef LED_TICK_PAUSE_EN
        // Pause press issued right after a tick stops the count at 6; resume needs 10 more edges.
        f0 = flag_cnt;
        ticks = 0;
        key_pause = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            cyc();
            if (i == 8) key_pause = 1'b1;
            if (tick_out === 1'b1) ticks++;
        end
        check("pause_no_ticks", ticks, 0);
        first = -1;
        key_pause = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            cyc();
            if (i == 8) key_pause = 1'b1;
            if (tick_out === 1'b1 && first < 0) first = i;
        end
        check("resume_first_tick", first, 16);
        check("pause_flags", flag_cnt - f0, 2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
